axi_csr_master: RTL and testbench
=================================

# axi_csr_master

Single-outstanding AXI4 master that turns a simple request/response command port into single-beat AXI read and write transactions. It is the initiator counterpart of the CSR slave blocks. Debug/host logic uses it to read PC registers and program reset-address registers over the AXI CSR fabric. The block has a bounded-wait timeout, so a hung slave can never lock the command port.

## Interface
- AXI_ID_WIDTH, 8, width of all AXI ID fields
- AXI_ADDR_WIDTH, 12, AXI address width
- AXI_DATA_WIDTH, 32, AXI data width; must be 32
- AXI_ID, 0, constant ID driven on arid/awid
- TIMEOUT_CYCLES, 256, maximum wait cycles per transaction; must be ≥2
- aclk  in  1  clock
- arstn  in  1  reset, asynchronous, active-low
- req_valid / req_ready  in / out  1  command handshake
- req_write  in  1  1 = write, 0 = read
- req_addr  in  AXI_ADDR_WIDTH  byte address; bits [1:0] ignored, driven as 0 on the bus
- req_wdata  in  32  write data
- req_wstrb  in  4  write byte strobes
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  AXI response code, or 2'b10 on ID mismatch
- rsp_timeout  out  1  transaction exceeded TIMEOUT_CYCLES
- AXI master ports: ar*/aw*/w*/r*/b* using standard AXI4 names and widths
  - arlen/awlen = 0, arsize/awsize = 3'b010, arburst/awburst = 2'b01
  - arcache/awcache/arprot/awprot/arqos/awqos/arlock/awlock = 0
  - wlast = 1 whenever wvalid is high

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP, DRAIN. Encoding is one-hot and registered.
- All AXI and response outputs are registered.
- Reset values:
  - req_ready = 1; every valid = 0; rready = bready = 0
  - rsp_rdata = 0, rsp_resp = 0, rsp_timeout = 0; address and data outputs = 0
  - state = IDLE
- IDLE:
  - req_ready is high only in IDLE.
  - On req_valid: latch the command, clear the timer, drop req_ready.
  - A read goes to RD_ADDR with arvalid = 1.
  - A write goes to WR_REQ with awvalid = 1 and wvalid = 1.
- RD_ADDR: hold arvalid and araddr stable until arready. On that handshake, arvalid = 0 and rready = 1; go to RD_DATA.
- RD_DATA:
  - On rvalid & rready: capture rdata into rsp_rdata and rresp into rsp_resp; rready = 0; go to RSP.
  - rid ≠ AXI_ID forces rsp_resp = 2'b10.
  - rlast is ignored.
- WR_REQ:
  - awvalid and wvalid are independent; each drops on its own handshake. Same-cycle and either-order completion are both legal.
  - When both have completed: bready = 1; go to WR_RESP.
- WR_RESP:
  - On bvalid: capture bresp into rsp_resp; bready = 0; rsp_rdata = 0; go to RSP.
  - bid ≠ AXI_ID forces rsp_resp = 2'b10.
- RSP: rsp_valid = 1 until rsp_ready. Then go to IDLE with req_ready = 1.
- Timeout:
  - The timer increments every cycle in RD_ADDR, RD_DATA, WR_REQ and WR_RESP. It saturates and is cleared on command accept.
  - When the timer reaches TIMEOUT_CYCLES-1 without completion, present rsp_valid = 1, rsp_timeout = 1, rsp_resp = 2'b10, rsp_rdata = 0.
  - The state then moves to DRAIN.
- DRAIN:
  - Any address/data valid still outstanding stays asserted until its handshake completes (AXI forbids withdrawal).
  - rready or bready is asserted.
  - The late response is consumed and discarded.
  - Exit to IDLE only after the outstanding handshakes are done, the response is consumed, and the timeout response has been accepted on rsp_ready.
- Completion and timeout in the same cycle: completion wins and rsp_timeout = 0.
- Async reset mid-transaction: all valids drop immediately and the state returns to IDLE. The system must reset the slave at the same time.

## Timing
- Command accepted at cycle N gives arvalid or awvalid/wvalid high at cycle N+1.
- Best-case read with arready and rvalid already high: AR handshake at N+1, R handshake at N+2, rsp_valid at N+3.
- Best-case write: AW/W handshake at N+1, B handshake at N+2, rsp_valid at N+3.
- Response accepted at cycle M gives req_ready high at M+1. Back-to-back throughput is one transaction per 4 cycles best case.
- No combinational paths from AXI inputs to AXI outputs or from rsp_ready to req_ready.

## Test plan
- Read to 0xC with the slave returning 0x00001234 and OKAY after 2 waits on arready and 3 on rvalid. Required: araddr = 0xC held stable while arvalid is high; rsp_rdata = 0x00001234, rsp_resp = 0, rsp_timeout = 0.
- Write 0x02300000 to 0x4 with wstrb = 0xF, slave takes awready 3 cycles before wready. Required: awvalid drops first, wvalid held until its handshake; bready is asserted only after both handshakes; rsp_resp = 0.
- Slave returns bid = 0x5 and OKAY. Required: rsp_resp = 2'b10.
- Slave never asserts rvalid, TIMEOUT_CYCLES = 16. Required: rsp_timeout = 1 exactly 16 cycles after the AR issue cycle; req_ready stays low; a late rvalid is drained; req_ready then returns to 1.
- rsp_ready held low for 10 cycles. Required: rsp_valid and response data stable throughout; no new arvalid/awvalid; req_ready stays 0.
- arstn asserted while in WR_REQ. Required: awvalid = wvalid = 0 immediately, req_ready = 1 after release; the next read completes normally.

Source files
------------

// File: rtl/axi_csr_master.sv
// Single-outstanding AXI4 master: one command in, one single-beat AXI read/write out, one response back.
// Bounded wait per transaction; a timed-out transaction is answered at once and its late AXI traffic drained.
module axi_csr_master #(
   parameter int                        AXI_ID_WIDTH   = 8,
   parameter int                        AXI_ADDR_WIDTH = 12,
   parameter int                        AXI_DATA_WIDTH = 32,
   parameter logic [AXI_ID_WIDTH-1:0]   AXI_ID         = '0,
   parameter int                        TIMEOUT_CYCLES = 256
) (
   input  logic                          aclk,
   input  logic                          arstn,
   input  logic                          i_req_valid,
   output logic                          o_req_ready,
   input  logic                          i_req_write,
   input  logic [AXI_ADDR_WIDTH-1:0]     i_req_addr,
   input  logic [AXI_DATA_WIDTH-1:0]     i_req_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0]   i_req_wstrb,
   output logic                          o_rsp_valid,
   input  logic                          i_rsp_ready,
   output logic [AXI_DATA_WIDTH-1:0]     o_rsp_rdata,
   output logic [1:0]                    o_rsp_resp,
   output logic                          o_rsp_timeout,
   output logic [AXI_ID_WIDTH-1:0]       o_arid,
   output logic [AXI_ADDR_WIDTH-1:0]     o_araddr,
   output logic [7:0]                    o_arlen,
   output logic [2:0]                    o_arsize,
   output logic [1:0]                    o_arburst,
   output logic                          o_arlock,
   output logic [3:0]                    o_arcache,
   output logic [2:0]                    o_arprot,
   output logic [3:0]                    o_arqos,
   output logic                          o_arvalid,
   input  logic                          i_arready,
   output logic [AXI_ID_WIDTH-1:0]       o_awid,
   output logic [AXI_ADDR_WIDTH-1:0]     o_awaddr,
   output logic [7:0]                    o_awlen,
   output logic [2:0]                    o_awsize,
   output logic [1:0]                    o_awburst,
   output logic                          o_awlock,
   output logic [3:0]                    o_awcache,
   output logic [2:0]                    o_awprot,
   output logic [3:0]                    o_awqos,
   output logic                          o_awvalid,
   input  logic                          i_awready,
   output logic [AXI_DATA_WIDTH-1:0]     o_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0]   o_wstrb,
   output logic                          o_wlast,
   output logic                          o_wvalid,
   input  logic                          i_wready,
   input  logic [AXI_ID_WIDTH-1:0]       i_rid,
   input  logic [AXI_DATA_WIDTH-1:0]     i_rdata,
   input  logic [1:0]                    i_rresp,
   input  logic                          i_rlast,
   input  logic                          i_rvalid,
   output logic                          o_rready,
   input  logic [AXI_ID_WIDTH-1:0]       i_bid,
   input  logic [1:0]                    i_bresp,
   input  logic                          i_bvalid,
   output logic                          o_bready
);

   localparam int                TW   = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]     TMAX = TW'(TIMEOUT_CYCLES - 1);
   localparam int                DW   = AXI_DATA_WIDTH;
   localparam int                AW   = AXI_ADDR_WIDTH;

   typedef enum logic [6:0] {
      S_IDLE    = 7'b0000001,
      S_RD_ADDR = 7'b0000010,
      S_RD_DATA = 7'b0000100,
      S_WR_REQ  = 7'b0001000,
      S_WR_RESP = 7'b0010000,
      S_RSP     = 7'b0100000,
      S_DRAIN   = 7'b1000000
   } state_t;

   state_t              r_state, w_state;
   logic [TW-1:0]       r_timer, w_timer;
   logic                r_is_write, w_is_write;
   logic                r_need_resp, w_need_resp;
   logic                r_req_ready, w_req_ready;
   logic                r_arvalid, w_arvalid;
   logic                r_awvalid, w_awvalid;
   logic                r_wvalid, w_wvalid;
   logic                r_rready, w_rready;
   logic                r_bready, w_bready;
   logic [AW-1:0]       r_addr, w_addr;
   logic [DW-1:0]       r_wdata, w_wdata;
   logic [DW/8-1:0]     r_wstrb, w_wstrb;
   logic                r_rsp_valid, w_rsp_valid;
   logic [DW-1:0]       r_rsp_rdata, w_rsp_rdata;
   logic [1:0]          r_rsp_resp, w_rsp_resp;
   logic                r_rsp_timeout, w_rsp_timeout;
   logic                w_busy, w_tmo, w_tmo_fire;
   logic                w_unused;

   // Burst end and the sub-word address bits carry no information for single-beat word access.
   assign w_unused = ^{i_rlast, i_req_addr[1:0]};

   assign w_busy = (r_state == S_RD_ADDR) || (r_state == S_RD_DATA) ||
                   (r_state == S_WR_REQ)  || (r_state == S_WR_RESP);
   assign w_tmo  = (r_timer == TMAX);

   always_comb begin
      w_state       = r_state;
      w_timer       = r_timer;
      w_is_write    = r_is_write;
      w_need_resp   = r_need_resp;
      w_req_ready   = r_req_ready;
      w_arvalid     = r_arvalid;
      w_awvalid     = r_awvalid;
      w_wvalid      = r_wvalid;
      w_rready      = r_rready;
      w_bready      = r_bready;
      w_addr        = r_addr;
      w_wdata       = r_wdata;
      w_wstrb       = r_wstrb;
      w_rsp_valid   = r_rsp_valid;
      w_rsp_rdata   = r_rsp_rdata;
      w_rsp_resp    = r_rsp_resp;
      w_rsp_timeout = r_rsp_timeout;
      w_tmo_fire    = 1'b0;
      if (w_busy && !w_tmo) w_timer = r_timer + 1'b1;

      case (r_state)
         S_IDLE: begin
            if (i_req_valid) begin
               w_req_ready = 1'b0;
               w_timer     = '0;
               w_is_write  = i_req_write;
               w_addr      = {i_req_addr[AW-1:2], 2'b00};
               w_wdata     = i_req_wdata;
               w_wstrb     = i_req_wstrb;
               if (i_req_write) begin
                  w_awvalid = 1'b1;
                  w_wvalid  = 1'b1;
                  w_state   = S_WR_REQ;
               end else begin
                  w_arvalid = 1'b1;
                  w_state   = S_RD_ADDR;
               end
            end
         end
         S_RD_ADDR: begin
            if (i_arready) begin
               w_arvalid = 1'b0;
               w_rready  = 1'b1;
               w_state   = S_RD_DATA;
            end else if (w_tmo) begin
               w_tmo_fire = 1'b1;
            end
         end
         S_RD_DATA: begin
            if (i_rvalid && r_rready) begin
               w_rsp_rdata   = i_rdata;
               w_rsp_resp    = (i_rid == AXI_ID) ? i_rresp : 2'b10;
               w_rsp_timeout = 1'b0;
               w_rsp_valid   = 1'b1;
               w_rready      = 1'b0;
               w_state       = S_RSP;
            end else if (w_tmo) begin
               w_tmo_fire = 1'b1;
            end
         end
         S_WR_REQ: begin
            w_awvalid = r_awvalid && !i_awready;
            w_wvalid  = r_wvalid && !i_wready;
            if (!w_awvalid && !w_wvalid) begin
               w_bready = 1'b1;
               w_state  = S_WR_RESP;
            end else if (w_tmo) begin
               w_tmo_fire = 1'b1;
            end
         end
         S_WR_RESP: begin
            if (i_bvalid && r_bready) begin
               w_rsp_rdata   = '0;
               w_rsp_resp    = (i_bid == AXI_ID) ? i_bresp : 2'b10;
               w_rsp_timeout = 1'b0;
               w_rsp_valid   = 1'b1;
               w_bready      = 1'b0;
               w_state       = S_RSP;
            end else if (w_tmo) begin
               w_tmo_fire = 1'b1;
            end
         end
         S_RSP: begin
            if (i_rsp_ready) begin
               w_rsp_valid = 1'b0;
               w_req_ready = 1'b1;
               w_state     = S_IDLE;
            end
         end
         S_DRAIN: begin
            // Valids already on the bus must complete; the late response is swallowed.
            w_arvalid = r_arvalid && !i_arready;
            w_awvalid = r_awvalid && !i_awready;
            w_wvalid  = r_wvalid && !i_wready;
            if (r_rready && i_rvalid) begin
               w_rready    = 1'b0;
               w_need_resp = 1'b0;
            end
            if (r_bready && i_bvalid) begin
               w_bready    = 1'b0;
               w_need_resp = 1'b0;
            end
            if (r_rsp_valid && i_rsp_ready) w_rsp_valid = 1'b0;
            if (!w_arvalid && !w_awvalid && !w_wvalid && !w_need_resp && !w_rsp_valid) begin
               w_req_ready = 1'b1;
               w_state     = S_IDLE;
            end
         end
         default: w_state = S_IDLE;
      endcase

      if (w_tmo_fire) begin
         w_rsp_valid   = 1'b1;
         w_rsp_timeout = 1'b1;
         w_rsp_resp    = 2'b10;
         w_rsp_rdata   = '0;
         w_need_resp   = 1'b1;
         w_rready      = !r_is_write;
         w_bready      = r_is_write;
         w_state       = S_DRAIN;
      end
   end

   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         r_state       <= S_IDLE;
         r_timer       <= '0;
         r_is_write    <= 1'b0;
         r_need_resp   <= 1'b0;
         r_req_ready   <= 1'b1;
         r_arvalid     <= 1'b0;
         r_awvalid     <= 1'b0;
         r_wvalid      <= 1'b0;
         r_rready      <= 1'b0;
         r_bready      <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_wstrb       <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_resp    <= 2'b00;
         r_rsp_timeout <= 1'b0;
      end else begin
         r_state       <= w_state;
         r_timer       <= w_timer;
         r_is_write    <= w_is_write;
         r_need_resp   <= w_need_resp;
         r_req_ready   <= w_req_ready;
         r_arvalid     <= w_arvalid;
         r_awvalid     <= w_awvalid;
         r_wvalid      <= w_wvalid;
         r_rready      <= w_rready;
         r_bready      <= w_bready;
         r_addr        <= w_addr;
         r_wdata       <= w_wdata;
         r_wstrb       <= w_wstrb;
         r_rsp_valid   <= w_rsp_valid;
         r_rsp_rdata   <= w_rsp_rdata;
         r_rsp_resp    <= w_rsp_resp;
         r_rsp_timeout <= w_rsp_timeout;
      end
   end

   assign o_req_ready   = r_req_ready;
   assign o_rsp_valid   = r_rsp_valid;
   assign o_rsp_rdata   = r_rsp_rdata;
   assign o_rsp_resp    = r_rsp_resp;
   assign o_rsp_timeout = r_rsp_timeout;
   assign o_arid        = AXI_ID;
   assign o_araddr      = r_addr;
   assign o_arlen       = 8'd0;
   assign o_arsize      = 3'b010;
   assign o_arburst     = 2'b01;
   assign o_arlock      = 1'b0;
   assign o_arcache     = 4'd0;
   assign o_arprot      = 3'd0;
   assign o_arqos       = 4'd0;
   assign o_arvalid     = r_arvalid;
   assign o_awid        = AXI_ID;
   assign o_awaddr      = r_addr;
   assign o_awlen       = 8'd0;
   assign o_awsize      = 3'b010;
   assign o_awburst     = 2'b01;
   assign o_awlock      = 1'b0;
   assign o_awcache     = 4'd0;
   assign o_awprot      = 3'd0;
   assign o_awqos       = 4'd0;
   assign o_awvalid     = r_awvalid;
   assign o_wdata       = r_wdata;
   assign o_wstrb       = r_wstrb;
   assign o_wlast       = 1'b1;
   assign o_wvalid      = r_wvalid;
   assign o_rready      = r_rready;
   assign o_bready      = r_bready;

endmodule

// File: tb/tb_axi_csr_master.sv
// Directed bench for axi_csr_master: hand-driven AXI slave, response scoreboard, TIMEOUT_CYCLES = 16.
module tb_axi_csr_master;

   localparam int TMO = 16;

   typedef struct packed {
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic        tmo;
   } rsp_t;

   logic        aclk = 1'b0;
   logic        arstn;
   logic        i_req_valid, o_req_ready, i_req_write;
   logic [11:0] i_req_addr;
   logic [31:0] i_req_wdata;
   logic [3:0]  i_req_wstrb;
   logic        o_rsp_valid, i_rsp_ready;
   logic [31:0] o_rsp_rdata;
   logic [1:0]  o_rsp_resp;
   logic        o_rsp_timeout;
   logic [7:0]  o_arid, o_awid, i_rid, i_bid;
   logic [11:0] o_araddr, o_awaddr;
   logic [7:0]  o_arlen, o_awlen;
   logic [2:0]  o_arsize, o_awsize, o_arprot, o_awprot;
   logic [1:0]  o_arburst, o_awburst;
   logic        o_arlock, o_awlock;
   logic [3:0]  o_arcache, o_awcache, o_arqos, o_awqos;
   logic        o_arvalid, i_arready, o_awvalid, i_awready;
   logic [31:0] o_wdata, i_rdata;
   logic [3:0]  o_wstrb;
   logic        o_wlast, o_wvalid, i_wready;
   logic [1:0]  i_rresp, i_bresp;
   logic        i_rlast, i_rvalid, o_rready, i_bvalid, o_bready;

   int   checks   = 0;
   int   failures = 0;
   rsp_t exp_q[$];

   always #5 aclk = ~aclk;

   axi_csr_master #(.TIMEOUT_CYCLES(TMO)) dut (
      .aclk(aclk), .arstn(arstn),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_write(i_req_write),
      .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
      .o_rsp_resp(o_rsp_resp), .o_rsp_timeout(o_rsp_timeout),
      .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
      .o_arburst(o_arburst), .o_arlock(o_arlock), .o_arcache(o_arcache), .o_arprot(o_arprot),
      .o_arqos(o_arqos), .o_arvalid(o_arvalid), .i_arready(i_arready),
      .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
      .o_awburst(o_awburst), .o_awlock(o_awlock), .o_awcache(o_awcache), .o_awprot(o_awprot),
      .o_awqos(o_awqos), .o_awvalid(o_awvalid), .i_awready(i_awready),
      .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
      .i_wready(i_wready),
      .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
      .i_rvalid(i_rvalid), .o_rready(o_rready),
      .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
   );

   task automatic tick();
      @(negedge aclk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present one command at a negedge, log its expected response, return one cycle after accept.
   task automatic issue(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input rsp_t e);
      int n = 0;
      while (!o_req_ready && n < 100) begin tick(); n++; end
      check("req_ready_before_issue", 64'(o_req_ready), 64'd1);
      i_req_valid = 1'b1; i_req_write = wr; i_req_addr = addr;
      i_req_wdata = wd; i_req_wstrb = ws;
      exp_q.push_back(e);
      tick();
      i_req_valid = 1'b0;
   endtask

   // Wait for rsp_valid, optionally stall rsp_ready, then compare against the scoreboard.
   task automatic get_rsp(input string tag, input int stall, input bit chk_ready);
      int   n = 0;
      rsp_t e;
      logic [34:0] obs0;
      while (!o_rsp_valid && n < 200) begin tick(); n++; end
      check({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'd1);
      obs0 = {o_rsp_rdata, o_rsp_resp, o_rsp_timeout};
      if (stall > 0) begin
         i_req_valid = 1'b1; i_req_write = 1'b0;
      end
      for (int i = 0; i < stall; i++) begin
         tick();
         check({tag, "_stall_stable"}, 64'({o_rsp_valid, o_rsp_rdata, o_rsp_resp, o_rsp_timeout}),
               64'({1'b1, obs0}));
         check({tag, "_stall_no_axi_valid"}, 64'({o_arvalid, o_awvalid}), 64'd0);
         check({tag, "_stall_req_ready"}, 64'(o_req_ready), 64'd0);
      end
      i_req_valid = 1'b0;
      check({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, "_rdata"}, 64'(o_rsp_rdata), 64'(e.rdata));
         check({tag, "_resp"}, 64'(o_rsp_resp), 64'(e.resp));
         check({tag, "_timeout"}, 64'(o_rsp_timeout), 64'(e.tmo));
      end
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;
      check({tag, "_rsp_valid_drop"}, 64'(o_rsp_valid), 64'd0);
      if (chk_ready) check({tag, "_req_ready_after"}, 64'(o_req_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      arstn = 1'b0;
      i_req_valid = 0; i_req_write = 0; i_req_addr = '0; i_req_wdata = '0; i_req_wstrb = '0;
      i_rsp_ready = 0; i_arready = 0; i_awready = 0; i_wready = 0;
      i_rid = '0; i_rdata = '0; i_rresp = '0; i_rlast = 1'b1; i_rvalid = 0;
      i_bid = '0; i_bresp = '0; i_bvalid = 0;
      tick(); tick();

      // Reset state and fixed AXI attributes
      check("rst_req_ready", 64'(o_req_ready), 64'd1);
      check("rst_valids", 64'({o_arvalid, o_awvalid, o_wvalid, o_rsp_valid}), 64'd0);
      check("rst_readies", 64'({o_rready, o_bready}), 64'd0);
      check("rst_rsp", 64'({o_rsp_rdata, o_rsp_resp, o_rsp_timeout}), 64'd0);
      check("rst_addr_data", 64'({o_araddr, o_awaddr, o_wdata}), 64'd0);
      check("ar_attr", 64'({o_arlen, o_arsize, o_arburst, o_arcache, o_arprot, o_arqos, o_arlock}),
            64'({8'd0, 3'b010, 2'b01, 4'd0, 3'd0, 4'd0, 1'b0}));
      check("aw_attr", 64'({o_awlen, o_awsize, o_awburst, o_awcache, o_awprot, o_awqos, o_awlock}),
            64'({8'd0, 3'b010, 2'b01, 4'd0, 3'd0, 4'd0, 1'b0}));
      arstn = 1'b1;
      tick();

      // Read 0xC: 2 waits on arready, 3 on rvalid
      issue(1'b0, 12'h00F, 32'h0, 4'h0, '{32'h0000_1234, 2'b00, 1'b0});
      for (int i = 0; i < 2; i++) begin
         check("rd1_arvalid_held", 64'(o_arvalid), 64'd1);
         check("rd1_araddr_stable", 64'(o_araddr), 64'h00C);
         tick();
      end
      check("rd1_araddr_at_hs", 64'({o_arvalid, o_araddr}), 64'({1'b1, 12'h00C}));
      i_arready = 1'b1; tick(); i_arready = 1'b0;
      check("rd1_ar_done", 64'({o_arvalid, o_rready}), 64'b01);
      for (int i = 0; i < 3; i++) begin
         check("rd1_rready_wait", 64'(o_rready), 64'd1);
         tick();
      end
      i_rvalid = 1'b1; i_rdata = 32'h0000_1234; i_rresp = 2'b00; i_rid = 8'h00;
      tick();
      i_rvalid = 1'b0;
      check("rd1_rready_drop", 64'(o_rready), 64'd0);
      get_rsp("rd1", 0, 1'b1);

      // Write 0x02300000 to 0x4: awready three cycles ahead of wready
      issue(1'b1, 12'h004, 32'h0230_0000, 4'hF, '{32'h0, 2'b00, 1'b0});
      check("wr1_aw_w_valid", 64'({o_awvalid, o_wvalid, o_wlast}), 64'b111);
      check("wr1_bus", 64'({o_awaddr, o_wdata, o_wstrb}), 64'({12'h004, 32'h0230_0000, 4'hF}));
      i_awready = 1'b1; tick(); i_awready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("wr1_w_held", 64'({o_awvalid, o_wvalid, o_wlast, o_bready}), 64'b0110);
         if (i < 2) tick();
      end
      i_wready = 1'b1; tick(); i_wready = 1'b0;
      check("wr1_w_done", 64'({o_wvalid, o_bready}), 64'b01);
      i_bvalid = 1'b1; i_bid = 8'h00; i_bresp = 2'b00;
      tick();
      i_bvalid = 1'b0;
      check("wr1_bready_drop", 64'(o_bready), 64'd0);
      get_rsp("wr1", 0, 1'b1);

      // Write with same-cycle AW/W, wrong bid, response held off for 10 cycles
      issue(1'b1, 12'h010, 32'hCAFE_F00D, 4'h3, '{32'h0, 2'b10, 1'b0});
      i_awready = 1'b1; i_wready = 1'b1; tick(); i_awready = 1'b0; i_wready = 1'b0;
      check("wr2_both_done", 64'({o_awvalid, o_wvalid, o_bready}), 64'b001);
      i_bvalid = 1'b1; i_bid = 8'h05; i_bresp = 2'b00;
      tick();
      i_bvalid = 1'b0; i_bid = 8'h00;
      get_rsp("wr2_bid", 10, 1'b1);

      // Best-case read: accept at N, rsp_valid at N+3, EXOKAY passed through
      i_arready = 1'b1; i_rvalid = 1'b1; i_rdata = 32'h89AB_CDEF; i_rresp = 2'b01;
      issue(1'b0, 12'h020, 32'h0, 4'h0, '{32'h89AB_CDEF, 2'b01, 1'b0});
      tick();
      check("rd2_not_yet", 64'(o_rsp_valid), 64'd0);
      tick();
      check("rd2_n_plus_3", 64'(o_rsp_valid), 64'd1);
      i_arready = 1'b0; i_rvalid = 1'b0;
      get_rsp("rd2", 0, 1'b1);

      // Read timeout: AR accepted, rvalid never comes until after the timeout response
      issue(1'b0, 12'h008, 32'h0, 4'h0, '{32'h0, 2'b10, 1'b1});
      i_arready = 1'b1;
      cyc = 0;
      while (!o_rsp_valid && cyc < 40) begin
         tick(); cyc++;
         if (cyc == 1) i_arready = 1'b0;
         if (!o_rsp_valid) check("tmo_req_ready_low", 64'(o_req_ready), 64'd0);
      end
      check("tmo_latency", 64'(cyc), 64'(TMO));
      check("tmo_drain_rready", 64'(o_rready), 64'd1);
      get_rsp("tmo", 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("tmo_drain_hold", 64'({o_req_ready, o_rready}), 64'b01);
         tick();
      end
      i_rvalid = 1'b1; i_rdata = 32'hDEAD_BEEF; i_rresp = 2'b00;
      tick();
      i_rvalid = 1'b0;
      check("tmo_drained", 64'({o_rready, o_rsp_valid, o_req_ready}), 64'b001);

      // Async reset while in WR_REQ
      issue(1'b1, 12'h00C, 32'h1111_2222, 4'hF, '{32'h0, 2'b00, 1'b0});
      check("rst_wr_pending", 64'({o_awvalid, o_wvalid}), 64'b11);
      #1 arstn = 1'b0;
      #1 check("rst_wr_valids_drop", 64'({o_awvalid, o_wvalid}), 64'd0);
      void'(exp_q.pop_back());
      tick();
      arstn = 1'b1;
      tick();
      check("rst_wr_req_ready", 64'(o_req_ready), 64'd1);
      i_arready = 1'b1; i_rvalid = 1'b1; i_rdata = 32'hA5A5_0001; i_rresp = 2'b00;
      issue(1'b0, 12'h004, 32'h0, 4'h0, '{32'hA5A5_0001, 2'b00, 1'b0});
      get_rsp("post_rst_rd", 0, 1'b1);
      i_arready = 1'b0; i_rvalid = 1'b0;

      check("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
